// File: rtl/seq_match_sched.sv
// Run controller for a programmable Moore serial pattern detector with hit counting.
// Optional macro SEQ_OVERLAP_EN keeps history on a hit so overlapping occurrences count.
module seq_match_sched #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] target,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   hist_sh;
  logic [FILL_W-1:0]  fill_sh;
  logic               hit_s;

  // Candidate history/fill if the current bit were taken, and whether it completes the pattern.
  always_comb begin
    hist_sh = {hist_q[PAT_W-2:0], x};
    if (fill_q == FILL_MAX) begin
      fill_sh = FILL_MAX;
    end else begin
      fill_sh = fill_q + FILL_W'(1);
    end
    hit_s = (fill_sh == FILL_MAX) && (hist_sh == pat_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pat_d  = pattern;
            tgt_d  = target;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            if (target == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_ARMED, ST_HIT: begin
          if ((state_q == ST_HIT) && (cnt_q == tgt_q)) begin
            // Target reached: any bit offered in this cycle is dropped.
            state_d = ST_DONE;
          end else begin
            state_d = ST_ARMED;
            if (x_valid) begin
              if (hit_s) begin
                state_d = ST_HIT;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef SEQ_OVERLAP_EN
                hist_d  = hist_sh;
                fill_d  = fill_sh;
`else
                hist_d  = '0;
                fill_d  = '0;
`endif
              end else begin
                hist_d = hist_sh;
                fill_d = fill_sh;
              end
            end else begin
              hist_d = hist_q;
              fill_d = fill_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z         = (state_q == ST_HIT);
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_HIT);
  assign done      = (state_q == ST_DONE);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed, table-driven bench for seq_match_sched with a hand-written async-reset sequence.
module tb_seq_match_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] target;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       z;
  logic [7:0] match_cnt;
  logic       done;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] target;
    logic       x;
    logic       x_valid;
    logic       e_z;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_cnt;
    string      name;
  } vec_t;

  vec_t vq[$];

  seq_match_sched #(.PAT_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .target    (target),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .z         (z),
    .match_cnt (match_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic st, input logic ab, input logic [3:0] pat,
                              input logic [7:0] tgt, input logic xb, input logic xv,
                              input logic ez, input logic eb, input logic ed,
                              input logic [7:0] ec, input string nm);
    vec_t v;
    v.start = st; v.abort = ab; v.pattern = pat; v.target = tgt;
    v.x = xb; v.x_valid = xv;
    v.e_z = ez; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec; v.name = nm;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic ez, input logic eb,
                            input logic ed, input logic [7:0] ec);
    check({nm, ".z"},    {31'd0, z},    {31'd0, ez});
    check({nm, ".busy"}, {31'd0, busy}, {31'd0, eb});
    check({nm, ".done"}, {31'd0, done}, {31'd0, ed});
    check({nm, ".cnt"},  {24'd0, match_cnt}, {24'd0, ec});
  endtask

  task automatic feed(input logic xb);
    x = xb; x_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pattern = 4'h0; target = 8'd0;
    x = 1'b0; x_valid = 1'b0;

    //   st    ab    pat    tgt    x     xv       z     busy  done  cnt
    // Test 1: pattern 1100, target 2, continuous stream
    add(1'b1, 1'b0, 4'hC, 8'd2, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t1_start");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t1_b1");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t1_b2");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t1_b3");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd1, "t1_b4");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t1_b5");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t1_b6");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t1_b7");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd2, "t1_b8");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b0, 1'b1, 8'd2, "t1_done");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b0, 1'b1, 8'd2, "t1_hold");
    // Test 2: pattern 1010, target 5, stream 1,0,1,0,1,0
    add(1'b1, 1'b0, 4'hA, 8'd5, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t2_start");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t2_b1");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t2_b2");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t2_b3");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd1, "t2_b4");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t2_b5");
`ifdef SEQ_OVERLAP_EN
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd2, "t2_b6");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd2, "t2_idle");
    add(1'b0, 1'b1, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 8'd2, "t2_abort");
`else
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t2_b6");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd1, "t2_idle");
    add(1'b0, 1'b1, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 8'd1, "t2_abort");
`endif
    // Test 4: target 0 finishes immediately
    add(1'b1, 1'b0, 4'hC, 8'd0, 1'b1, 1'b1,   1'b0, 1'b0, 1'b1, 8'd0, "t4_start");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b0, 1'b1, 8'd0, "t4_hold");
    // Test 3: x_valid on alternate cycles, invalid x values are decoys
    add(1'b1, 1'b0, 4'hC, 8'd3, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t3_start");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t3_v1");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t3_i1");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t3_v2");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t3_i2");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t3_v3");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t3_i3");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd1, "t3_v4");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd1, "t3_after");
    // Test 5: abort after 1,1,0 then restart and feed 0
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t5_b1");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t5_b2");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd1, "t5_b3");
    add(1'b0, 1'b1, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b0, 1'b0, 8'd1, "t5_abort");
    add(1'b1, 1'b0, 4'hC, 8'd3, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t5_start");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t5_b0");
    // abort beats start in the same cycle
    add(1'b1, 1'b1, 4'hC, 8'd1, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 8'd0, "ab_st");
    // start during a run and pattern/target changes are ignored; target 1
    add(1'b1, 1'b0, 4'hC, 8'd1, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 8'd0, "t7_start");
    add(1'b1, 1'b0, 4'h3, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t7_b1_st");
    add(1'b0, 1'b0, 4'h3, 8'd0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t7_b2");
    add(1'b0, 1'b0, 4'h3, 8'd0, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 8'd0, "t7_b3");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1,   1'b1, 1'b1, 1'b0, 8'd1, "t7_b4");
    add(1'b0, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1,   1'b0, 1'b0, 1'b1, 8'd1, "t7_done");

    // reset state, checked while rst is held low
    #12;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      start   = vq[i].start;
      abort   = vq[i].abort;
      pattern = vq[i].pattern;
      target  = vq[i].target;
      x       = vq[i].x;
      x_valid = vq[i].x_valid;
      @(posedge clk); #1;
      check_outs(vq[i].name, vq[i].e_z, vq[i].e_busy, vq[i].e_done, vq[i].e_cnt);
    end

    // Test 6: asynchronous reset while in HIT
    start = 1'b1; abort = 1'b0; pattern = 4'hC; target = 8'd2; x_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b0);
    x_valid = 1'b0;
    check_outs("t6_hit", 1'b1, 1'b1, 1'b0, 8'd1);
    #2 rst = 1'b0;
    #1;
    check_outs("t6_async", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outs("t6_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
